// File: rtl/sum_pe_pkg.sv
// Shared types for the summing processing element: FSM state encoding and
// the width of the delivered-result counter.
package sum_pe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SEND  = 2'd2
   } state_t;

   localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/sum_pe.sv
// Summing PE: adds the low OPW bits of every beat of one AXI-Stream packet and
// emits the total as a single-beat result toward RESULT_DEST.
module sum_pe
   import sum_pe_pkg::*;
#(
   parameter int TDATAW      = 32,
   parameter int TDESTW      = 4,
   parameter int TIDW        = 2,
   parameter int OPW         = 8,
   parameter int RESULT_DEST = 0
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 AXIS_S_TVALID,
   output logic                 AXIS_S_TREADY,
   input  logic [TDATAW-1:0]    AXIS_S_TDATA,
   input  logic                 AXIS_S_TLAST,
   input  logic [TIDW-1:0]      AXIS_S_TID,
   input  logic [TDESTW-1:0]    AXIS_S_TDEST,
   output logic                 AXIS_M_TVALID,
   input  logic                 AXIS_M_TREADY,
   output logic [TDATAW-1:0]    AXIS_M_TDATA,
   output logic                 AXIS_M_TLAST,
   output logic [TIDW-1:0]      AXIS_M_TID,
   output logic [TDESTW-1:0]    AXIS_M_TDEST,
   output logic [PKT_CNT_W-1:0] PKT_CNT,
   output state_t               o_dbg_state
);

   // A beat moves on a stream whenever TVALID and TREADY are both high at a
   // rising edge; ready/valid here come from state only, never from inputs.

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [TDATAW-1:0]      r_acc;
   logic [TIDW-1:0]        r_tid;
   logic                   r_first;
   logic [PKT_CNT_W-1:0]   r_pkt_cnt;
   logic                   w_s_hs;
   logic                   w_m_hs;
   logic [TDATAW-1:0]      w_operand;
   logic                   w_unused_ok;

   assign w_s_hs      = AXIS_S_TVALID && AXIS_S_TREADY;
   assign w_m_hs      = AXIS_M_TVALID && AXIS_M_TREADY;
   assign w_operand   = {{(TDATAW-OPW){1'b0}}, AXIS_S_TDATA[OPW-1:0]};
   assign w_unused_ok = ^{AXIS_S_TDEST, AXIS_S_TDATA[TDATAW-1:OPW]};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = ACCUM;
         ACCUM:   if (w_s_hs && AXIS_S_TLAST) w_state_nxt = SEND;
         SEND:    if (w_m_hs) w_state_nxt = ACCUM;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      AXIS_S_TREADY = 1'b0;
      AXIS_M_TVALID = 1'b0;
      AXIS_M_TLAST  = 1'b0;
      case (r_state)
         ACCUM: AXIS_S_TREADY = 1'b1;
         SEND: begin
            AXIS_M_TVALID = 1'b1;
            AXIS_M_TLAST  = 1'b1;
         end
         default: ;
      endcase
   end

   // Input is never accepted in SEND, so the two handshakes cannot coincide.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_acc     <= '0;
         r_tid     <= '0;
         r_first   <= 1'b1;
         r_pkt_cnt <= '0;
      end else if (w_m_hs) begin
         r_acc     <= '0;
         r_first   <= 1'b1;
         r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end else if (w_s_hs) begin
         r_acc <= r_acc + w_operand;
         if (r_first) begin
            r_tid   <= AXIS_S_TID;
            r_first <= 1'b0;
         end
      end
   end

   assign AXIS_M_TDATA = r_acc;
   assign AXIS_M_TID   = r_tid;
   assign AXIS_M_TDEST = TDESTW'(RESULT_DEST);
   assign PKT_CNT      = r_pkt_cnt;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sum_pe.sv
// Bench for sum_pe: directed packets plus randomized traffic, checked every
// cycle against a packet-level sum model and a queue of expected results.
module tb_sum_pe;

   localparam int TDATAW      = 32;
   localparam int TDESTW      = 4;
   localparam int TIDW        = 2;
   localparam int RESULT_DEST = 0;

   logic                CLK;
   logic                RST_N;
   logic                AXIS_S_TVALID;
   logic                AXIS_S_TREADY;
   logic [TDATAW-1:0]   AXIS_S_TDATA;
   logic                AXIS_S_TLAST;
   logic [TIDW-1:0]     AXIS_S_TID;
   logic [TDESTW-1:0]   AXIS_S_TDEST;
   logic                AXIS_M_TVALID;
   logic                AXIS_M_TREADY;
   logic [TDATAW-1:0]   AXIS_M_TDATA;
   logic                AXIS_M_TLAST;
   logic [TIDW-1:0]     AXIS_M_TID;
   logic [TDESTW-1:0]   AXIS_M_TDEST;
   logic [15:0]         PKT_CNT;
   sum_pe_pkg::state_t  dbg_state;

   sum_pe #(
      .TDATAW(TDATAW), .TDESTW(TDESTW), .TIDW(TIDW), .OPW(8), .RESULT_DEST(RESULT_DEST)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY),
      .AXIS_S_TDATA(AXIS_S_TDATA), .AXIS_S_TLAST(AXIS_S_TLAST),
      .AXIS_S_TID(AXIS_S_TID), .AXIS_S_TDEST(AXIS_S_TDEST),
      .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
      .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST),
      .AXIS_M_TID(AXIS_M_TID), .AXIS_M_TDEST(AXIS_M_TDEST),
      .PKT_CNT(PKT_CNT), .o_dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   int                n_checks = 0;
   int                n_pass   = 0;
   bit                done     = 0;
   logic [TDATAW-1:0] exp_q[$];
   logic [TIDW-1:0]   exp_tid_q[$];
   logic [TDATAW-1:0] m_acc;
   logic [TIDW-1:0]   m_tid;
   bit                m_first;
   logic [15:0]       m_cnt;
   bit                exp_valid_next;
   bit                prev_stall;
   logic [TDATAW-1:0] prev_data;
   logic [TIDW-1:0]   prev_tid;
   int                rel_cnt;
   logic [TDATAW-1:0] hist_d[256];
   logic [TIDW-1:0]   hist_t[256];
   int                h_n = 0;
   bit                m_rand = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic summary();
      if (!done) begin
         done = 1;
         $display("%0d/%0d checks passed", n_pass, n_checks);
      end
   endtask

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge CLK) begin
      if (!RST_N) begin
         chk("rst_s_tready", AXIS_S_TREADY, 0);
         chk("rst_m_tvalid", AXIS_M_TVALID, 0);
         chk("rst_m_tdata",  AXIS_M_TDATA, 0);
         chk("rst_m_tlast",  AXIS_M_TLAST, 0);
         chk("rst_m_tid",    AXIS_M_TID, 0);
         chk("rst_m_tdest",  AXIS_M_TDEST, RESULT_DEST);
         chk("rst_pkt_cnt",  PKT_CNT, 0);
         exp_q.delete();
         exp_tid_q.delete();
         m_acc = '0; m_tid = '0; m_first = 1; m_cnt = '0;
         exp_valid_next = 0; prev_stall = 0; rel_cnt = 0;
      end else begin
         if (rel_cnt < 3) rel_cnt++;
         if (rel_cnt == 1) chk("release_idle_tready", AXIS_S_TREADY, 0);
         if (rel_cnt == 2) chk("release_accum_tready", AXIS_S_TREADY, 1);
         chk("tlast_follows_tvalid", AXIS_M_TLAST, AXIS_M_TVALID);
         chk("tdest", AXIS_M_TDEST, RESULT_DEST);
         chk("pkt_cnt", PKT_CNT, m_cnt);
         chk("no_tready_in_send", AXIS_S_TREADY && AXIS_M_TVALID, 0);
         if (exp_valid_next) chk("latency_tvalid", AXIS_M_TVALID, 1);
         exp_valid_next = 0;
         if (prev_stall) begin
            chk("stall_tvalid", AXIS_M_TVALID, 1);
            chk("stall_tdata", AXIS_M_TDATA, prev_data);
            chk("stall_tid", AXIS_M_TID, prev_tid);
         end
         if (AXIS_M_TVALID) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", AXIS_M_TDATA, 32'hDEAD_BEEF);
            end else begin
               chk("result_tdata", AXIS_M_TDATA, exp_q[0]);
               chk("result_tid", AXIS_M_TID, exp_tid_q[0]);
               if (AXIS_M_TREADY) begin
                  void'(exp_q.pop_front());
                  void'(exp_tid_q.pop_front());
                  m_cnt = m_cnt + 16'd1;
                  if (h_n < 256) begin
                     hist_d[h_n] = AXIS_M_TDATA;
                     hist_t[h_n] = AXIS_M_TID;
                  end
                  h_n++;
               end
            end
         end
         prev_stall = AXIS_M_TVALID && !AXIS_M_TREADY;
         prev_data  = AXIS_M_TDATA;
         prev_tid   = AXIS_M_TID;
         if (AXIS_S_TVALID && AXIS_S_TREADY) begin
            if (m_first) begin
               m_tid   = AXIS_S_TID;
               m_first = 0;
            end
            m_acc = m_acc + {24'd0, AXIS_S_TDATA[7:0]};
            if (AXIS_S_TLAST) begin
               exp_q.push_back(m_acc);
               exp_tid_q.push_back(m_tid);
               m_acc = '0;
               m_first = 1;
               exp_valid_next = 1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   always @(posedge CLK) begin
      #1;
      if (m_rand) AXIS_M_TREADY = 1'($urandom_range(0, 1));
   end

   // Called at posedge+1; returns at posedge+1 just after the beat was taken.
   task automatic send_beat(input logic [7:0] op, input logic [23:0] hi,
                            input logic last, input logic [TIDW-1:0] tid);
      int t;
      AXIS_S_TVALID = 1;
      AXIS_S_TDATA  = {hi, op};
      AXIS_S_TLAST  = last;
      AXIS_S_TID    = tid;
      AXIS_S_TDEST  = 4'($urandom);
      t = 0;
      forever begin
         @(negedge CLK);
         if (AXIS_S_TREADY) break;
         t++;
         if (t > 200) begin
            chk("s_accept_timeout", 0, 1);
            break;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic s_idle();
      AXIS_S_TVALID = 0;
      AXIS_S_TLAST  = 0;
   endtask

   task automatic wait_results(input int n);
      int t;
      t = 0;
      while (h_n < n && t < 400) begin
         @(negedge CLK);
         t++;
      end
      chk("result_wait", 32'(h_n >= n), 1);
      @(posedge CLK);
      @(negedge CLK);
      @(posedge CLK);
      #1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int base;
      int t;
      int n_rand;
      RST_N = 0;
      AXIS_S_TVALID = 0; AXIS_S_TDATA = '0; AXIS_S_TLAST = 0;
      AXIS_S_TID = '0; AXIS_S_TDEST = '0; AXIS_M_TREADY = 0;
      repeat (3) @(posedge CLK);
      #1 RST_N = 1;

      // Three-beat packet, sink always ready.
      AXIS_M_TREADY = 1;
      base = h_n;
      send_beat(8'h12, 24'h0, 0, 2'd2);
      send_beat(8'h34, 24'h0, 0, 2'd1);
      send_beat(8'h56, 24'h0, 1, 2'd3);
      s_idle();
      wait_results(base + 1);
      chk("pkt3_sum", hist_d[base], 32'h9C);
      chk("pkt3_tid", hist_t[base], 2);
      chk("pkt3_cnt", PKT_CNT, 1);

      // Upper TDATA bits ignored.
      base = h_n;
      send_beat(8'hFF, 24'hABCD00, 0, 2'd1);
      send_beat(8'hFF, 24'hABCD00, 1, 2'd0);
      s_idle();
      wait_results(base + 1);
      chk("upper_ignored_sum", hist_d[base], 32'h1FE);
      chk("upper_ignored_tid", hist_t[base], 1);

      // Sink stalls for 5 cycles while the result is pending.
      AXIS_M_TREADY = 0;
      base = h_n;
      send_beat(8'h03, 24'h0, 0, 2'd3);
      send_beat(8'h04, 24'h0, 1, 2'd0);
      s_idle();
      t = 0;
      while (!AXIS_M_TVALID && t < 20) begin
         @(negedge CLK);
         t++;
      end
      repeat (5) begin
         @(negedge CLK);
         chk("stall_s_tready_low", AXIS_S_TREADY, 0);
         chk("stall_m_tdata", AXIS_M_TDATA, 32'h7);
         chk("stall_m_tvalid", AXIS_M_TVALID, 1);
      end
      @(posedge CLK);
      #1 AXIS_M_TREADY = 1;
      wait_results(base + 1);
      chk("stall_result", hist_d[base], 32'h7);
      chk("stall_tid", hist_t[base], 3);

      // Back-to-back single-beat packets.
      base = h_n;
      send_beat(8'h01, 24'h0, 1, 2'd0);
      send_beat(8'h02, 24'h0, 1, 2'd1);
      s_idle();
      wait_results(base + 2);
      chk("b2b_first", hist_d[base], 32'h1);
      chk("b2b_second", hist_d[base + 1], 32'h2);
      chk("b2b_second_tid", hist_t[base + 1], 1);

      // Reset in the middle of a packet discards it.
      send_beat(8'h10, 24'h0, 0, 2'd2);
      send_beat(8'h20, 24'h0, 0, 2'd2);
      s_idle();
      RST_N = 0;
      repeat (2) @(posedge CLK);
      #1 RST_N = 1;
      base = h_n;
      send_beat(8'h05, 24'h0, 1, 2'd1);
      s_idle();
      wait_results(base + 1);
      chk("after_reset_sum", hist_d[base], 32'h5);
      chk("after_reset_count", h_n - base, 1);
      chk("after_reset_pkt_cnt", PKT_CNT, 1);

      // Randomized traffic with random sink backpressure.
      m_rand = 1;
      base = h_n;
      n_rand = 40;
      for (int p = 0; p < n_rand; p++) begin
         int len;
         logic [TIDW-1:0] tid;
         len = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 6);
         tid = 2'($urandom);
         for (int b = 0; b < len; b++) begin
            send_beat(8'($urandom), 24'($urandom), (b == len - 1), tid);
            if ($urandom_range(0, 3) == 0) begin
               s_idle();
               repeat ($urandom_range(1, 3)) @(posedge CLK);
               #1;
            end
         end
         s_idle();
      end
      m_rand = 0;
      @(posedge CLK);
      #2 AXIS_M_TREADY = 1;
      wait_results(base + n_rand);
      chk("random_all_delivered", h_n - base, n_rand);
      chk("random_queue_empty", exp_q.size(), 0);

      summary();
      $finish;
   end

   initial begin
      #2000000;
      chk("watchdog_timeout", 0, 1);
      summary();
      $finish;
   end

endmodule
